// File: rtl/f_classify_pipe.sv
// f_classify_pipe: single-stage floating-point operand classifier with a
// valid/ready output register and saturating per-category statistics.
module f_classify_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [9:0]           out_class,
    input  logic                 clr,
    output logic [CNT_W-1:0]     cnt_nan,
    output logic [CNT_W-1:0]     cnt_inf,
    output logic [CNT_W-1:0]     cnt_zero,
    output logic [CNT_W-1:0]     cnt_sub,
    output logic                 sticky_nan,
    output logic                 sticky_snan
);

    localparam int W = 1 + EXP_W + MAN_W;

    // Bit positions of the one-hot class vector.
    localparam logic [3:0] C_NEG_INF  = 4'd0;
    localparam logic [3:0] C_NEG_NORM = 4'd1;
    localparam logic [3:0] C_NEG_SUB  = 4'd2;
    localparam logic [3:0] C_NEG_ZERO = 4'd3;
    localparam logic [3:0] C_POS_ZERO = 4'd4;
    localparam logic [3:0] C_POS_SUB  = 4'd5;
    localparam logic [3:0] C_POS_NORM = 4'd6;
    localparam logic [3:0] C_POS_INF  = 4'd7;
    localparam logic [3:0] C_SNAN     = 4'd8;
    localparam logic [3:0] C_QNAN     = 4'd9;

    function automatic logic [9:0] classify(input logic [W-1:0] d);
        logic             sgn;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        logic             exp_ones;
        logic             exp_zero;
        logic             man_zero;
        logic [3:0]       idx;
        sgn      = d[W-1];
        e        = d[W-2:MAN_W];
        m        = d[MAN_W-1:0];
        exp_ones = &e;
        exp_zero = ~|e;
        man_zero = ~|m;
        // NaN ignores the sign; the quiet bit is the significand MSB.
        if (exp_ones && !man_zero) begin
            idx = m[MAN_W-1] ? C_QNAN : C_SNAN;
        end else if (exp_ones) begin
            idx = sgn ? C_NEG_INF : C_POS_INF;
        end else if (exp_zero && man_zero) begin
            idx = sgn ? C_NEG_ZERO : C_POS_ZERO;
        end else if (exp_zero) begin
            idx = sgn ? C_NEG_SUB : C_POS_SUB;
        end else begin
            idx = sgn ? C_NEG_NORM : C_POS_NORM;
        end
        classify = 10'd1 << idx;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (&c) ? c : c + CNT_W'(1);
    endfunction

    logic             out_valid_r;
    logic [9:0]       out_class_r;
    logic [CNT_W-1:0] cnt_nan_r, cnt_inf_r, cnt_zero_r, cnt_sub_r;
    logic             sticky_nan_r, sticky_snan_r;

    logic             in_ready_s;
    logic             accept_s;
    logic [9:0]       cls_s;
    logic             is_nan_s, is_snan_s, is_inf_s, is_zero_s, is_sub_s;
    logic [CNT_W-1:0] base_nan_s, base_inf_s, base_zero_s, base_sub_s;
    logic [CNT_W-1:0] cnt_nan_nx_s, cnt_inf_nx_s, cnt_zero_nx_s, cnt_sub_nx_s;
    logic             sticky_nan_nx_s, sticky_snan_nx_s;

    // Handshake decode and operand classification.
    always_comb begin
        in_ready_s = ~out_valid_r | out_ready;
        accept_s   = in_valid & in_ready_s;
        cls_s      = classify(in_data);
        is_nan_s   = cls_s[C_QNAN] | cls_s[C_SNAN];
        is_snan_s  = cls_s[C_SNAN];
        is_inf_s   = cls_s[C_NEG_INF] | cls_s[C_POS_INF];
        is_zero_s  = cls_s[C_NEG_ZERO] | cls_s[C_POS_ZERO];
        is_sub_s   = cls_s[C_NEG_SUB] | cls_s[C_POS_SUB];
    end

    // Next statistics: clear first, then count the operand accepted this cycle.
    always_comb begin
        base_nan_s       = clr ? {CNT_W{1'b0}} : cnt_nan_r;
        base_inf_s       = clr ? {CNT_W{1'b0}} : cnt_inf_r;
        base_zero_s      = clr ? {CNT_W{1'b0}} : cnt_zero_r;
        base_sub_s       = clr ? {CNT_W{1'b0}} : cnt_sub_r;
        cnt_nan_nx_s     = (accept_s && is_nan_s)  ? sat_inc(base_nan_s)  : base_nan_s;
        cnt_inf_nx_s     = (accept_s && is_inf_s)  ? sat_inc(base_inf_s)  : base_inf_s;
        cnt_zero_nx_s    = (accept_s && is_zero_s) ? sat_inc(base_zero_s) : base_zero_s;
        cnt_sub_nx_s     = (accept_s && is_sub_s)  ? sat_inc(base_sub_s)  : base_sub_s;
        sticky_nan_nx_s  = (clr ? 1'b0 : sticky_nan_r)  | (accept_s & is_nan_s);
        sticky_snan_nx_s = (clr ? 1'b0 : sticky_snan_r) | (accept_s & is_snan_s);
    end

    // Output register: load on accept, drain on transfer, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_class_r <= 10'd0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_class_r <= cls_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_nan_r     <= {CNT_W{1'b0}};
            cnt_inf_r     <= {CNT_W{1'b0}};
            cnt_zero_r    <= {CNT_W{1'b0}};
            cnt_sub_r     <= {CNT_W{1'b0}};
            sticky_nan_r  <= 1'b0;
            sticky_snan_r <= 1'b0;
        end else begin
            cnt_nan_r     <= cnt_nan_nx_s;
            cnt_inf_r     <= cnt_inf_nx_s;
            cnt_zero_r    <= cnt_zero_nx_s;
            cnt_sub_r     <= cnt_sub_nx_s;
            sticky_nan_r  <= sticky_nan_nx_s;
            sticky_snan_r <= sticky_snan_nx_s;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_class   = out_class_r;
    assign cnt_nan     = cnt_nan_r;
    assign cnt_inf     = cnt_inf_r;
    assign cnt_zero    = cnt_zero_r;
    assign cnt_sub     = cnt_sub_r;
    assign sticky_nan  = sticky_nan_r;
    assign sticky_snan = sticky_snan_r;

endmodule

// File: tb/tb_f_classify_pipe.sv
// Self-checking bench for f_classify_pipe: directed literal cases plus a
// randomized run compared every cycle against a queue-based reference model.
module tb_f_classify_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, default parameters.
    logic        rst, in_valid, in_ready, out_valid, out_ready, clr;
    logic [31:0] in_data;
    logic [9:0]  out_class;
    logic [15:0] cnt_nan, cnt_inf, cnt_zero, cnt_sub;
    logic        sticky_nan, sticky_snan;

    // Auxiliary instances: 2-bit counters and half precision.
    logic        a_rst;
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_clr;
    logic [31:0] c_in_data;
    logic [9:0]  c_out_class;
    logic [1:0]  c_cnt_nan, c_cnt_inf, c_cnt_zero, c_cnt_sub;
    logic        c_sticky_nan, c_sticky_snan;
    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_clr;
    logic [15:0] h_in_data;
    logic [9:0]  h_out_class;
    logic [15:0] h_cnt_nan, h_cnt_inf, h_cnt_zero, h_cnt_sub;
    logic        h_sticky_nan, h_sticky_snan;

    f_classify_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .clr(clr), .cnt_nan(cnt_nan), .cnt_inf(cnt_inf),
        .cnt_zero(cnt_zero), .cnt_sub(cnt_sub), .sticky_nan(sticky_nan),
        .sticky_snan(sticky_snan)
    );

    f_classify_pipe #(.CNT_W(2)) dut_c2 (
        .clk(clk), .rst(a_rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_class(c_out_class), .clr(c_clr), .cnt_nan(c_cnt_nan), .cnt_inf(c_cnt_inf),
        .cnt_zero(c_cnt_zero), .cnt_sub(c_cnt_sub), .sticky_nan(c_sticky_nan),
        .sticky_snan(c_sticky_snan)
    );

    f_classify_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(a_rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in_data(h_in_data), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .out_class(h_out_class), .clr(h_clr), .cnt_nan(h_cnt_nan), .cnt_inf(h_cnt_inf),
        .cnt_zero(h_cnt_zero), .cnt_sub(h_cnt_sub), .sticky_nan(h_sticky_nan),
        .sticky_snan(h_sticky_snan)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference classification from field values: returns the class bit index.
    function automatic int ref_class(input logic [31:0] d);
        int e, m;
        bit neg;
        neg = d[31];
        e   = int'(d[30:23]);
        m   = int'(d[22:0]);
        if (e == 255 && m != 0) return (m >= (1 << 22)) ? 9 : 8;
        if (e == 255)           return neg ? 0 : 7;
        if (e == 0 && m == 0)   return neg ? 3 : 4;
        if (e == 0)             return neg ? 2 : 5;
        return neg ? 1 : 6;
    endfunction

    function automatic logic [31:0] rand_operand();
        logic        s;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        case ($urandom_range(0, 6))
            0: return {s, 8'hFF, 1'b1, m[21:0]};
            1: return {s, 8'hFF, 1'b0, 22'($urandom_range(1, 32'h3FFFFF))};
            2: return {s, 8'hFF, 23'd0};
            3: return {s, 8'h00, 23'd0};
            4: return {s, 8'h00, 23'($urandom_range(1, 32'h7FFFFF))};
            5: return {s, 8'($urandom_range(1, 254)), m};
            default: return 32'($urandom);
        endcase
    endfunction

    // Reference model: pending results as a queue, counters as plain integers.
    localparam int CMAX = 65535;
    int q[$];
    int m_nan = 0, m_inf = 0, m_zero = 0, m_sub = 0;
    bit m_snan_any = 1'b0, m_ssnan = 1'b0;
    bit cmp_en = 1'b0;

    always @(posedge clk) begin
        bit acc;
        int k;
        if (rst) begin
            q.delete();
            m_nan = 0; m_inf = 0; m_zero = 0; m_sub = 0;
            m_snan_any = 1'b0; m_ssnan = 1'b0;
        end else begin
            acc = in_valid && (q.size() == 0 || out_ready);
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (clr) begin
                m_nan = 0; m_inf = 0; m_zero = 0; m_sub = 0;
                m_snan_any = 1'b0; m_ssnan = 1'b0;
            end
            if (acc) begin
                k = ref_class(in_data);
                q.push_back(k);
                if (k >= 8) begin
                    m_nan = (m_nan < CMAX) ? m_nan + 1 : m_nan;
                    m_snan_any = 1'b1;
                    if (k == 8) m_ssnan = 1'b1;
                end else if (k == 0 || k == 7) begin
                    m_inf = (m_inf < CMAX) ? m_inf + 1 : m_inf;
                end else if (k == 3 || k == 4) begin
                    m_zero = (m_zero < CMAX) ? m_zero + 1 : m_zero;
                end else if (k == 2 || k == 5) begin
                    m_sub = (m_sub < CMAX) ? m_sub + 1 : m_sub;
                end
            end
        end
    end

    // Per-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", in_ready, (q.size() == 0 || out_ready));
            chk("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) chk("out_class", out_class, 32'd1 << q[0]);
            chk("cnt_nan", cnt_nan, m_nan);
            chk("cnt_inf", cnt_inf, m_inf);
            chk("cnt_zero", cnt_zero, m_zero);
            chk("cnt_sub", cnt_sub, m_sub);
            chk("sticky_nan", sticky_nan, m_snan_any);
            chk("sticky_snan", sticky_snan, m_ssnan);
        end
    end

    logic [31:0] s32 [6] = '{32'h7FC00000, 32'h7F800001, 32'hFF800000,
                             32'h80000000, 32'h00000001, 32'h3F800000};
    logic [9:0]  e32 [6] = '{10'h200, 10'h100, 10'h001, 10'h008, 10'h020, 10'h040};
    logic [15:0] s16 [4] = '{16'h7E00, 16'h7C00, 16'h8001, 16'h3C00};
    logic [9:0]  e16 [4] = '{10'h200, 10'h080, 10'h004, 10'h040};

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0; in_data = 32'd0;
        a_rst = 1'b1;
        c_in_valid = 1'b0; c_out_ready = 1'b1; c_clr = 1'b0; c_in_data = 32'd0;
        h_in_valid = 1'b0; h_out_ready = 1'b1; h_clr = 1'b0; h_in_data = 16'd0;

        @(posedge clk); #1;
        cmp_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; a_rst = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_class", out_class, 10'd0);
        chk("rst_cnt_nan", cnt_nan, 16'd0);
        chk("rst_sticky_nan", sticky_nan, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);

        // Reference stream, one operand per cycle.
        out_ready = 1'b1; in_valid = 1'b1; in_data = s32[0];
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("stream_class", out_class, e32[i]);
            chk("stream_valid", out_valid, 1'b1);
            if (i < 5) in_data = s32[i + 1];
            else in_valid = 1'b0;
        end
        chk("stream_cnt_nan", cnt_nan, 16'd2);
        chk("stream_cnt_inf", cnt_inf, 16'd1);
        chk("stream_cnt_zero", cnt_zero, 16'd1);
        chk("stream_cnt_sub", cnt_sub, 16'd1);
        chk("stream_sticky_nan", sticky_nan, 1'b1);
        chk("stream_sticky_snan", sticky_snan, 1'b1);

        // Backpressure: -inf accepted, +subnormal waits three stalled cycles.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hFF800000;
        @(posedge clk); #1;
        in_data = 32'h00000001;
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_class", out_class, 10'h001);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_next_class", out_class, 10'h020);
        chk("bp_next_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_drain_valid", out_valid, 1'b0);

        // Clear together with accept of a signalling NaN.
        clr = 1'b1; in_valid = 1'b1; in_data = 32'h7F800001;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_cnt_nan", cnt_nan, 16'd1);
        chk("clr_cnt_inf", cnt_inf, 16'd0);
        chk("clr_cnt_zero", cnt_zero, 16'd0);
        chk("clr_cnt_sub", cnt_sub, 16'd0);
        chk("clr_sticky_snan", sticky_snan, 1'b1);

        // Reset while a result is pending and an operand is offered.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h7F800000;
        chk("prerst_valid", out_valid, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("rst2_valid", out_valid, 1'b0);
        chk("rst2_class", out_class, 10'd0);
        chk("rst2_cnt_nan", cnt_nan, 16'd0);
        chk("rst2_cnt_inf", cnt_inf, 16'd0);
        chk("rst2_sticky_nan", sticky_nan, 1'b0);
        chk("rst2_sticky_snan", sticky_snan, 1'b0);
        chk("rst2_in_ready", in_ready, 1'b1);

        // Saturation with 2-bit counters.
        c_in_valid = 1'b1; c_in_data = 32'h7F800000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("sat_cnt_inf", c_cnt_inf, (i + 1 < 3) ? i + 1 : 3);
        end
        c_in_valid = 1'b0;

        // Half precision classification.
        h_in_valid = 1'b1; h_in_data = s16[0];
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("half_class", h_out_class, e16[i]);
            if (i < 3) h_in_data = s16[i + 1];
            else h_in_valid = 1'b0;
        end

        // Randomized traffic with occasional clear and reset.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 299) == 0);
            clr       = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = rand_operand();
        end
        @(posedge clk); #1;
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
